// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared RAM port between the instruction and data caches.
// Data wins ties unless a waiting fetch has already been passed over STARVE_LIMIT times.
module cache_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IGNT = 2'b01,
    DGNT = 2'b10
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;
  localparam logic [2:0] SCNT_MAX   = 3'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [2:0]  scnt_q, scnt_d;
  logic        ramREN_q, ramREN_d;
  logic        ramWEN_q, ramWEN_d;
  logic [31:0] ramaddr_q, ramaddr_d;
  logic [31:0] ramstore_q, ramstore_d;

  logic dReq;
  logic iDone;
  logic dDone;
  logic ramEnded;

  assign dReq     = dREN | dWEN;
  assign ramEnded = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);

  // A dropped request is an abort, so completion is gated by the request still being held.
  assign iDone = (state_q == IGNT) && iREN && (ramstate == RAM_ACCESS);
  assign dDone = (state_q == DGNT) && dReq && (ramstate == RAM_ACCESS);

  assign iwait    = ~iDone;
  assign dwait    = ~dDone;
  assign iload    = ramload;
  assign dload    = ramload;
  assign ramREN   = ramREN_q;
  assign ramWEN   = ramWEN_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;

  always_comb begin
    state_d    = state_q;
    scnt_d     = scnt_q;
    ramREN_d   = ramREN_q;
    ramWEN_d   = ramWEN_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    case (state_q)
      IDLE: begin
        if (dReq && !(iREN && (scnt_q == SCNT_MAX))) begin
          state_d    = DGNT;
          ramWEN_d   = dWEN;
          ramREN_d   = ~dWEN;
          ramaddr_d  = daddr;
          ramstore_d = dWEN ? dstore : 32'h0;
          if (!iREN)
            scnt_d = 3'd0;
          else if (scnt_q < SCNT_MAX)
            scnt_d = scnt_q + 3'd1;
        end else if (iREN) begin
          state_d    = IGNT;
          ramREN_d   = 1'b1;
          ramWEN_d   = 1'b0;
          ramaddr_d  = iaddr;
          ramstore_d = 32'h0;
          scnt_d     = 3'd0;
        end
      end
      IGNT, DGNT: begin
        // Completion, error and abort all pass through one IDLE cycle before re-arbitration.
        if (((state_q == IGNT) ? !iREN : !dReq) || ramEnded) begin
          state_d    = IDLE;
          ramREN_d   = 1'b0;
          ramWEN_d   = 1'b0;
          ramaddr_d  = 32'h0;
          ramstore_d = 32'h0;
        end
      end
      default: begin
        state_d    = IDLE;
        ramREN_d   = 1'b0;
        ramWEN_d   = 1'b0;
        ramaddr_d  = 32'h0;
        ramstore_d = 32'h0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      scnt_q     <= 3'd0;
      ramREN_q   <= 1'b0;
      ramWEN_q   <= 1'b0;
      ramaddr_q  <= 32'h0;
      ramstore_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      ramREN_q   <= ramREN_d;
      ramWEN_q   <= ramWEN_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed and randomized bench for cache_mem_arbiter, checked against a
// transaction-level model of which cache owns the RAM port.
module tb_cache_mem_arbiter;

  localparam int LIMIT = 4;
  localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  cache_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int testsRun = 0;
  int failCount = 0;

  // Reference model: owner 0 = nobody, 1 = instruction cache, 2 = data cache.
  int          mOwner = 0;
  int          mStreak = 0;
  bit          mWrite = 0;
  logic [31:0] mAddr = 0, mStore = 0;

  logic        sIwait, sDwait, sRamREN, sRamWEN;
  logic [31:0] sRamaddr, sRamstore, sIload;
  int          strobeCyc, iDoneCyc, dDoneCyc;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] want);
    testsRun++;
    assert (obs === want) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic checkOutput();
    bit iReqOk, dReqOk;
    iReqOk = (mOwner == 1) && iREN && (ramstate == ACCESS);
    dReqOk = (mOwner == 2) && (dREN || dWEN) && (ramstate == ACCESS);
    checkVal("ramREN", ramREN, (mOwner == 1) || (mOwner == 2 && !mWrite));
    checkVal("ramWEN", ramWEN, (mOwner == 2) && mWrite);
    checkVal("ramaddr", ramaddr, (mOwner != 0) ? mAddr : 32'h0);
    checkVal("ramstore", ramstore, (mOwner == 2 && mWrite) ? mStore : 32'h0);
    checkVal("iwait", iwait, !iReqOk);
    checkVal("dwait", dwait, !dReqOk);
    checkVal("iload", iload, ramload);
    checkVal("dload", dload, ramload);
    checkVal("scnt", dut.scnt_q, mStreak);
  endtask

  task automatic applyStimulus(input logic i, input logic [31:0] ia, input logic dr,
                               input logic dw, input logic [31:0] da, input logic [31:0] ds,
                               input logic [1:0] rs, input logic [31:0] rl);
    iREN = i; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
  endtask

  // One clock: check at the falling edge, advance the model across the rising edge.
  task automatic cycle();
    int          nOwner, nStreak;
    bit          nWrite;
    logic [31:0] nAddr, nStore;
    @(negedge CLK);
    checkOutput();
    sIwait = iwait; sDwait = dwait; sRamREN = ramREN; sRamWEN = ramWEN;
    sRamaddr = ramaddr; sRamstore = ramstore;
    if (ramREN || ramWEN) strobeCyc++;
    if (!iwait) begin iDoneCyc++; sIload = iload; end
    if (!dwait) dDoneCyc++;
    nOwner = mOwner; nStreak = mStreak; nWrite = mWrite; nAddr = mAddr; nStore = mStore;
    if (mOwner == 0) begin
      if ((dREN || dWEN) && !(iREN && mStreak == LIMIT)) begin
        nOwner = 2; nWrite = dWEN; nAddr = daddr; nStore = dstore;
        nStreak = iREN ? ((mStreak + 1 > LIMIT) ? LIMIT : mStreak + 1) : 0;
      end else if (iREN) begin
        nOwner = 1; nWrite = 0; nAddr = iaddr; nStreak = 0;
      end
    end else begin
      bit held;
      held = (mOwner == 1) ? iREN : (dREN || dWEN);
      if (!held || ramstate == ACCESS || ramstate == ERROR) nOwner = 0;
    end
    @(posedge CLK);
    mOwner = nOwner; mStreak = nStreak; mWrite = nWrite; mAddr = nAddr; mStore = nStore;
    #1;
  endtask

  task automatic clearCounts();
    strobeCyc = 0; iDoneCyc = 0; dDoneCyc = 0;
  endtask

  initial begin
    int dataGrants;
    bit instrGot;
    nRST = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    repeat (2) @(posedge CLK);
    #1;
    checkOutput();
    nRST = 1'b1;

    // Single instruction fetch, RAM answers on the third grant cycle.
    clearCounts();
    applyStimulus(1, 32'h40, 0, 0, 0, 0, BUSY, 32'h0);
    repeat (3) cycle();
    applyStimulus(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h2402_0005);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    cycle();
    checkVal("fetchStrobeCycles", strobeCyc, 3);
    checkVal("fetchDoneCycles", iDoneCyc, 1);
    checkVal("fetchData", sIload, 32'h2402_0005);
    checkVal("fetchIdleAfter", dut.state_q, 2'b00);

    // Simultaneous fetch and write: data goes first, then the fetch.
    applyStimulus(1, 32'h44, 0, 1, 32'h80, 32'hDEAD_BEEF, BUSY, 0);
    cycle();
    cycle();
    checkVal("prioWEN", sRamWEN, 1);
    checkVal("prioStore", sRamstore, 32'hDEAD_BEEF);
    checkVal("prioAddr", sRamaddr, 32'h80);
    applyStimulus(1, 32'h44, 0, 1, 32'h80, 32'hDEAD_BEEF, ACCESS, 0);
    cycle();
    checkVal("prioDataDone", sDwait, 0);
    applyStimulus(1, 32'h44, 0, 0, 0, 0, BUSY, 0);
    cycle();
    cycle();
    checkVal("prioThenFetchREN", sRamREN, 1);
    checkVal("prioThenFetchAddr", sRamaddr, 32'h44);
    applyStimulus(1, 32'h44, 0, 0, 0, 0, ACCESS, 32'h1111_2222);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    cycle();

    // Starvation: data kept requesting while a fetch waits.
    dataGrants = 0;
    instrGot = 0;
    for (int k = 0; k < 8 && !instrGot; k++) begin
      applyStimulus(1, 32'h48, 1, 0, 32'h200, 0, BUSY, 0);
      cycle();
      applyStimulus(1, 32'h48, 1, 0, 32'h200, 0, ACCESS, 32'h3000 + k);
      cycle();
      if (!sDwait) dataGrants++;
      if (!sIwait) instrGot = 1;
    end
    checkVal("starveDataGrants", dataGrants, LIMIT);
    checkVal("starveInstrGranted", instrGot, 1);
    checkVal("starveScntCleared", dut.scnt_q, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    cycle();

    // RAM error forces a retry after one idle cycle.
    clearCounts();
    applyStimulus(0, 0, 1, 0, 32'h100, 0, ERROR, 0);
    cycle();
    cycle();
    checkVal("errDwaitHigh", sDwait, 1);
    applyStimulus(0, 0, 1, 0, 32'h100, 0, BUSY, 0);
    cycle();
    checkVal("errIdleREN", sRamREN, 0);
    applyStimulus(0, 0, 1, 0, 32'h100, 0, ACCESS, 32'h5555_AAAA);
    cycle();
    checkVal("errRetryDone", sDwait, 0);
    checkVal("errRetryAddr", sRamaddr, 32'h100);
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    cycle();

    // Abort: fetch withdrawn while the RAM is still busy.
    clearCounts();
    applyStimulus(1, 32'h60, 0, 0, 0, 0, BUSY, 0);
    cycle();
    cycle();
    applyStimulus(0, 32'h60, 0, 0, 0, 0, BUSY, 0);
    cycle();
    cycle();
    checkVal("abortIdleREN", sRamREN, 0);
    checkVal("abortNoPulse", iDoneCyc, 0);

    // Asynchronous reset in the middle of a data write.
    applyStimulus(1, 32'h70, 0, 1, 32'h300, 32'h1234_5678, BUSY, 0);
    cycle();
    #2;
    nRST = 1'b0;
    #1;
    checkVal("rstWEN", ramWEN, 0);
    checkVal("rstDwait", dwait, 1);
    checkVal("rstScnt", dut.scnt_q, 0);
    mOwner = 0; mStreak = 0; mWrite = 0; mAddr = 0; mStore = 0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    cycle();
    checkVal("rstReleaseIdle", sRamWEN, 0);
    cycle();
    checkVal("rstRegrantWEN", sRamWEN, 1);
    checkVal("rstRegrantAddr", sRamaddr, 32'h300);
    applyStimulus(1, 32'h70, 0, 1, 32'h300, 32'h1234_5678, ACCESS, 0);
    cycle();
    applyStimulus(1, 32'h70, 0, 0, 0, 0, BUSY, 0);
    cycle();
    applyStimulus(1, 32'h70, 0, 0, 0, 0, ACCESS, 32'h7);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, FREE, 0);
    cycle();

    // Random traffic that honours the hold-until-done protocol.
    for (int n = 0; n < 400; n++) begin
      int r;
      if (iREN) begin
        if (!sIwait) begin
          iREN = 1'($urandom_range(0, 1));
          iaddr = $urandom & 32'hFFFF_FFFC;
        end else if ($urandom_range(0, 19) == 0) begin
          iREN = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        iREN = 1'b1;
        iaddr = $urandom & 32'hFFFF_FFFC;
      end
      if (dREN || dWEN) begin
        if (!sDwait || $urandom_range(0, 19) == 0) begin
          dWEN = 1'b0;
          dREN = 1'b0;
        end
      end else if ($urandom_range(0, 1) == 0) begin
        dWEN = 1'($urandom_range(0, 1));
        dREN = dWEN ? 1'($urandom_range(0, 1)) : 1'b1;
        daddr = $urandom;
        dstore = $urandom;
      end
      r = $urandom_range(0, 9);
      ramstate = (r < 4) ? BUSY : (r < 8) ? ACCESS : (r == 8) ? ERROR : FREE;
      ramload = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single unified RAM port between the instruction cache and the data cache. Each cache presents a held request; the arbiter grants one at a time through a small state machine, drives the RAM request signals for the granted side and returns a one-cycle completion (wait low) with the loaded word. Data requests take priority, and a starvation counter guarantees instruction-fetch progress. The arbiter sits between the two caches' memory-side ports and the RAM model.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while an instruction request is waiting; range 1..7.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request, held until iwait low.
- iaddr  in  32  instruction word address.
- iwait  out  1  low for exactly the completion cycle of an instruction read.
- iload  out  32  instruction data; valid only when iwait low.
- dREN  in  1  data read request, held until dwait low.
- dWEN  in  1  data write request, held until dwait low; wins over dREN if both are high.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  low for exactly the completion cycle of a data access.
- dload  out  32  read data; valid only when dwait low.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  00 FREE, 01 BUSY, 10 ACCESS (done this cycle), 11 ERROR.

## Operation
- States: IDLE, IGNT, DGNT, held in a 2-bit state register.
- IDLE: RAM strobes are 0, ramaddr is 0, ramstore is 0. Arbitration, in priority order:
  - (dREN|dWEN) and not (iREN and scnt==STARVE_LIMIT): go to DGNT.
  - iREN: go to IGNT.
  - Otherwise: stay in IDLE.
- IGNT: ramREN=1, ramaddr=iaddr.
  - ramstate==ACCESS: iwait=0, go to IDLE.
  - ramstate==ERROR: iwait stays 1, go to IDLE and re-arbitrate (retry).
  - iREN drops before completion (abort): go to IDLE, no completion pulse.
- DGNT: ramaddr=daddr.
  - dWEN: ramWEN=1, ramstore=dstore. Otherwise ramREN=1.
  - Completion, ERROR and abort rules are the same as IGNT, using dwait and (dREN|dWEN).
- iload=ramload and dload=ramload at all times, as a combinational pass-through.
- iwait=1 and dwait=1 in every cycle except the respective completion cycle.
- Starvation counter scnt is 3 bits, reset to 0, updated on each IDLE→grant transition:
  - Data grant with iREN high: scnt+1, saturating at STARVE_LIMIT.
  - Data grant with iREN low: scnt=0.
  - Instruction grant: scnt=0.
- A request arriving while the other side is granted waits. It is never preempted mid-transaction.

## Timing
- Reset, async: state=IDLE, scnt=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
- Grant latency is 1 cycle. A request seen in IDLE at edge N puts the RAM strobe high in cycle N+1.
- Minimum access is 2 cycles from the request (IDLE cycle, then grant cycle with ramstate=ACCESS).
- Completion is combinational on ramstate: the wait output goes low in the same cycle ACCESS is seen.
- After every completion, error or abort there is one IDLE cycle. Back-to-back accesses therefore cost a minimum of 2 cycles each.
- A simultaneous iREN and dREN in IDLE grants data unless scnt==STARVE_LIMIT.
- Reset mid-transaction returns to IDLE immediately and drops the strobes. The interrupted access is not completed.
- Outputs are glitch-free relative to registered state. Only the wait and load outputs depend combinationally on ramstate and ramload.

## Test plan
- Single instruction fetch: iREN=1, iaddr=0x0000_0040, RAM answers ACCESS on the 3rd grant cycle with ramload=0x2402_0005. Required: ramREN=1 and ramaddr=0x40 for 3 cycles; iwait=0 and iload=0x24020005 for exactly one cycle; state back in IDLE.
- Data write priority: iREN and dWEN rise together, daddr=0x80, dstore=0xDEAD_BEEF. Required: DGNT first with ramWEN=1 and ramstore=0xDEADBEEF. After dwait pulses and dWEN drops, IGNT follows.
- Starvation with STARVE_LIMIT=4: iREN held high while dREN is re-asserted immediately after every completion. Required: exactly 4 data grants, then an instruction grant, then scnt=0.
- ERROR retry: dREN at 0x100, first grant returns ramstate=ERROR. Required: dwait stays 1, one IDLE cycle, then the access is re-granted. A second grant returning ACCESS pulses dwait=0.
- Abort: iREN drops after 1 IGNT cycle with ramstate=BUSY. Required: next cycle is IDLE with ramREN=0 and no iwait pulse.
- Reset mid-access: nRST pulled low during DGNT with dWEN=1. Required: ramWEN=0, dwait=1, scnt=0 immediately (asynchronously). After release, the held dWEN is re-granted in the second cycle.
